midi_voice_alloc: RTL and testbench

Polyphonic MIDI voice allocator for GBMidi. Consumes the byte stream from `uart_rx` through its valid/ready handshake, parses channel-voice messages with running status, and assigns note-on/note-off events to a parametrised pool of voices. It drives per-voice gate, note, velocity and trigger buses to the Game Boy sound generators, generalising the fixed two-note output (`note_out`, `note_out2`) and the flat `poly_note_out` bus to N voices with steal and retrigger behaviour.

---
 rtl/midi_voice_alloc_if.sv | 8 +
 rtl/midi_voice_alloc.sv | 140 ++++++++++++++
 tb/tb_midi_voice_alloc.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/midi_voice_alloc_if.sv
// midi_voice_alloc_if: MIDI byte stream valid/ready handshake
interface midi_voice_alloc_if;
  logic [7:0] midi_data;
  logic       midi_send;
  logic       midi_ready;
  modport master (output midi_data, midi_send, input midi_ready);
  modport slave (input midi_data, midi_send, output midi_ready);
endinterface

// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: MIDI parser and polyphonic voice allocator; define MIDI_VOICE_STEAL_EN to steal the oldest voice when full
module midi_voice_alloc #(
  parameter int VOICES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  midi_voice_alloc_if.slave     bus,
  input  logic [3:0]            channel,
  input  logic                  omni,
  output logic [VOICES-1:0]     voice_gate,
  output logic [7*VOICES-1:0]   voice_note,
  output logic [7*VOICES-1:0]   voice_vel,
  output logic [VOICES-1:0]     voice_trig,
  output logic [4:0]            active_count
);
  localparam int AGE_W = $clog2(VOICES);
`ifdef MIDI_VOICE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif
  typedef enum logic {RECV, EXEC} state_t;
  state_t state, state_nx;
  logic rs_v, idx, acc, done, pass, exec, note_on, note_off, all_off, assign_en;
  logic hit_any, free_any;
  logic [2:0] rs_cmd, m_cmd;
  logic [3:0] rs_ch;
  logic [6:0] d0, m_d0, m_d1;
  logic [AGE_W-1:0] hit_k, free_k, old_k, k;
  logic [4:0] count;
  logic [6:0] note_r [VOICES];
  logic [6:0] vel_r [VOICES];
  logic [AGE_W-1:0] age_r [VOICES];
  assign bus.midi_ready = state == RECV && !reset;
  assign acc = bus.midi_send && bus.midi_ready;
  assign done = acc && !bus.midi_data[7] && rs_v && (idx || rs_cmd[2:1] == 2'b10);
  assign pass = omni || rs_ch == channel;
  assign exec = state == EXEC;
  assign note_on = exec && m_cmd == 3'b001 && m_d1 != 7'd0;
  assign note_off = exec && (m_cmd == 3'b000 || (m_cmd == 3'b001 && m_d1 == 7'd0));
  assign all_off = exec && m_cmd == 3'b011 && m_d0 == 7'h7B;
  assign k = hit_any ? hit_k : free_any ? free_k : old_k;
  assign assign_en = note_on && (hit_any || free_any || STEAL);
  // FSM state register
  always_ff @(posedge clk)
    state <= reset ? RECV : state_nx;
  // Enter EXEC for one cycle on a completed, channel-matched message
  always_comb
    state_nx = (state == RECV && done && pass) ? EXEC : RECV;
  // Byte parser with running status; realtime bytes pass through untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_v <= 1'b0;
      rs_cmd <= '0;
      rs_ch <= '0;
      idx <= 1'b0;
      d0 <= '0;
      m_cmd <= '0;
      m_d0 <= '0;
      m_d1 <= '0;
    end else if (acc) begin
      if (bus.midi_data[7]) begin
        if (bus.midi_data[7:3] != 5'b11111) begin
          rs_v <= bus.midi_data[7:4] != 4'hF;
          rs_cmd <= bus.midi_data[6:4];
          rs_ch <= bus.midi_data[3:0];
          idx <= 1'b0;
        end
      end else if (rs_v) begin
        idx <= !done;
        d0 <= bus.midi_data[6:0];
        if (done) begin
          m_cmd <= rs_cmd;
          m_d0 <= idx ? d0 : bus.midi_data[6:0];
          m_d1 <= bus.midi_data[6:0];
        end
      end
    end
  end
  // Candidate search: lowest matching voice, lowest free voice, oldest voice
  always_comb begin
    hit_any = 1'b0;
    free_any = 1'b0;
    hit_k = '0;
    free_k = '0;
    old_k = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (voice_gate[i] && note_r[i] == m_d0) begin
        hit_any = 1'b1;
        hit_k = AGE_W'(i);
      end
      if (!voice_gate[i]) begin
        free_any = 1'b1;
        free_k = AGE_W'(i);
      end
      if (age_r[i] == AGE_W'(VOICES - 1))
        old_k = AGE_W'(i);
    end
  end
  // Voice state: assignment with age reordering, note-off and all-notes-off
  always_ff @(posedge clk) begin
    if (reset) begin
      voice_gate <= '0;
      voice_trig <= '0;
      active_count <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note_r[i] <= '0;
        vel_r[i] <= '0;
        age_r[i] <= AGE_W'(i);
      end
    end else begin
      voice_trig <= '0;
      active_count <= count;
      for (int i = 0; i < VOICES; i++) begin
        if (assign_en) begin
          if (AGE_W'(i) == k) begin
            voice_gate[i] <= 1'b1;
            voice_trig[i] <= 1'b1;
            note_r[i] <= m_d0;
            vel_r[i] <= m_d1;
            age_r[i] <= '0;
          end else if (age_r[i] < age_r[k])
            age_r[i] <= age_r[i] + 1'b1;
        end else if ((note_off && note_r[i] == m_d0) || all_off)
          voice_gate[i] <= 1'b0;
      end
    end
  end
  // Pack per-voice registers onto flat buses and count held voices
  always_comb begin
    count = '0;
    voice_note = '0;
    voice_vel = '0;
    for (int i = 0; i < VOICES; i++) begin
      voice_note[7*i +: 7] = note_r[i];
      voice_vel[7*i +: 7] = vel_r[i];
      count = count + 5'(voice_gate[i]);
    end
  end
endmodule

// File: tb/tb_midi_voice_alloc.sv
// tb_midi_voice_alloc: directed checks of parsing, allocation, steal and reset behaviour
module tb_midi_voice_alloc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] channel = 4'd0;
  logic omni = 1'b0;
  logic [7:0] voice_gate, voice_trig;
  logic [55:0] voice_note, voice_vel;
  logic [4:0] active_count;
  int checks = 0;
  int errors = 0;
  midi_voice_alloc_if bus ();
  midi_voice_alloc #(.VOICES(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .channel(channel), .omni(omni),
    .voice_gate(voice_gate), .voice_note(voice_note), .voice_vel(voice_vel),
    .voice_trig(voice_trig), .active_count(active_count)
  );
  always #5 clk = ~clk;
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!bus.midi_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.midi_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got 0 exp 1");
    end
    bus.midi_data = b;
    bus.midi_send = 1'b1;
    @(negedge clk);
    bus.midi_send = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.midi_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", bus.midi_ready); end
    checks++; if (voice_gate !== 8'h00) begin errors++; $display("FAIL rst_gate got %h exp 00", voice_gate); end
    checks++; if (voice_note !== 56'h0) begin errors++; $display("FAIL rst_note got %h exp 0", voice_note); end
    checks++; if (voice_vel !== 56'h0) begin errors++; $display("FAIL rst_vel got %h exp 0", voice_vel); end
    checks++; if (voice_trig !== 8'h00) begin errors++; $display("FAIL rst_trig got %h exp 00", voice_trig); end
    checks++; if (active_count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", active_count); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.midi_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", bus.midi_ready); end
  endtask
  task automatic test_note_on();
    do_reset();
    send(8'h90); send(8'h3C); send(8'h64);
    checks++; if (bus.midi_ready !== 1'b0) begin errors++; $display("FAIL on_stall got %b exp 0", bus.midi_ready); end
    @(negedge clk);
    checks++; if (voice_gate !== 8'h01) begin errors++; $display("FAIL on_gate got %h exp 01", voice_gate); end
    checks++; if (voice_note[6:0] !== 7'h3C) begin errors++; $display("FAIL on_note got %h exp 3c", voice_note[6:0]); end
    checks++; if (voice_vel[6:0] !== 7'h64) begin errors++; $display("FAIL on_vel got %h exp 64", voice_vel[6:0]); end
    checks++; if (voice_trig !== 8'h01) begin errors++; $display("FAIL on_trig got %h exp 01", voice_trig); end
    checks++; if (active_count !== 5'd0) begin errors++; $display("FAIL on_count_lat got %0d exp 0", active_count); end
    @(negedge clk);
    checks++; if (voice_trig !== 8'h00) begin errors++; $display("FAIL on_trig_end got %h exp 00", voice_trig); end
    checks++; if (active_count !== 5'd1) begin errors++; $display("FAIL on_count got %0d exp 1", active_count); end
  endtask
  task automatic test_running_status();
    do_reset();
    send(8'h90); send(8'h3C); send(8'h40);
    send(8'h3E); send(8'h40);
    send(8'h3C); send(8'h00);
    @(negedge clk);
    @(negedge clk);
    checks++; if (voice_gate !== 8'h02) begin errors++; $display("FAIL rs_gate got %h exp 02", voice_gate); end
    checks++; if (voice_note[13:7] !== 7'h3E) begin errors++; $display("FAIL rs_note1 got %h exp 3e", voice_note[13:7]); end
    checks++; if (voice_note[6:0] !== 7'h3C) begin errors++; $display("FAIL rs_note0_kept got %h exp 3c", voice_note[6:0]); end
    checks++; if (active_count !== 5'd1) begin errors++; $display("FAIL rs_count got %0d exp 1", active_count); end
  endtask
  task automatic test_realtime_filter();
    do_reset();
    send(8'h90); send(8'h40); send(8'hF8); send(8'h50);
    @(negedge clk);
    checks++; if (voice_gate !== 8'h01) begin errors++; $display("FAIL rt_gate got %h exp 01", voice_gate); end
    checks++; if (voice_note[6:0] !== 7'h40) begin errors++; $display("FAIL rt_note got %h exp 40", voice_note[6:0]); end
    checks++; if (voice_vel[6:0] !== 7'h50) begin errors++; $display("FAIL rt_vel got %h exp 50", voice_vel[6:0]); end
    send(8'h91); send(8'h3C); send(8'h64);
    checks++; if (bus.midi_ready !== 1'b1) begin errors++; $display("FAIL flt_nostall got %b exp 1", bus.midi_ready); end
    @(negedge clk);
    checks++; if (voice_gate !== 8'h01) begin errors++; $display("FAIL flt_gate got %h exp 01", voice_gate); end
    omni = 1'b1;
    send(8'hF0); send(8'h45); send(8'h40);
    @(negedge clk);
    checks++; if (voice_gate !== 8'h01) begin errors++; $display("FAIL sysex_gate got %h exp 01", voice_gate); end
    send(8'h91); send(8'h45); send(8'h40);
    @(negedge clk);
    checks++; if (voice_gate !== 8'h03) begin errors++; $display("FAIL omni_gate got %h exp 03", voice_gate); end
    checks++; if (voice_note[13:7] !== 7'h45) begin errors++; $display("FAIL omni_note got %h exp 45", voice_note[13:7]); end
    omni = 1'b0;
  endtask
  task automatic test_full_pool();
    do_reset();
    send(8'h90);
    for (int n = 8'h30; n <= 8'h37; n++) begin
      send(8'(n)); send(8'h7F);
    end
    @(negedge clk);
    checks++; if (voice_gate !== 8'hFF) begin errors++; $display("FAIL full_gate got %h exp ff", voice_gate); end
    send(8'h38); send(8'h40);
    @(negedge clk);
`ifdef MIDI_VOICE_STEAL_EN
    checks++; if (voice_trig !== 8'h01) begin errors++; $display("FAIL steal_trig got %h exp 01", voice_trig); end
    checks++; if (voice_note[6:0] !== 7'h38) begin errors++; $display("FAIL steal_note got %h exp 38", voice_note[6:0]); end
    checks++; if (voice_vel[6:0] !== 7'h40) begin errors++; $display("FAIL steal_vel got %h exp 40", voice_vel[6:0]); end
`else
    checks++; if (voice_trig !== 8'h00) begin errors++; $display("FAIL drop_trig got %h exp 00", voice_trig); end
    checks++; if (voice_note[6:0] !== 7'h30) begin errors++; $display("FAIL drop_note got %h exp 30", voice_note[6:0]); end
    checks++; if (voice_vel[6:0] !== 7'h7F) begin errors++; $display("FAIL drop_vel got %h exp 7f", voice_vel[6:0]); end
`endif
    checks++; if (voice_gate !== 8'hFF) begin errors++; $display("FAIL full_gate2 got %h exp ff", voice_gate); end
    send(8'h39); send(8'h40);
    @(negedge clk);
`ifdef MIDI_VOICE_STEAL_EN
    checks++; if (voice_trig !== 8'h02) begin errors++; $display("FAIL steal2_trig got %h exp 02", voice_trig); end
    checks++; if (voice_note[13:7] !== 7'h39) begin errors++; $display("FAIL steal2_note got %h exp 39", voice_note[13:7]); end
`else
    checks++; if (voice_trig !== 8'h00) begin errors++; $display("FAIL drop2_trig got %h exp 00", voice_trig); end
    checks++; if (voice_note[13:7] !== 7'h31) begin errors++; $display("FAIL drop2_note got %h exp 31", voice_note[13:7]); end
`endif
  endtask
  task automatic test_retrigger();
    do_reset();
    send(8'h90); send(8'h3C); send(8'h40);
    send(8'h3C); send(8'h7F);
    @(negedge clk);
    checks++; if (voice_gate !== 8'h01) begin errors++; $display("FAIL rtg_gate got %h exp 01", voice_gate); end
    checks++; if (voice_vel[6:0] !== 7'h7F) begin errors++; $display("FAIL rtg_vel got %h exp 7f", voice_vel[6:0]); end
    checks++; if (voice_trig !== 8'h01) begin errors++; $display("FAIL rtg_trig got %h exp 01", voice_trig); end
    send(8'h3E); send(8'h40);
    send(8'h3C); send(8'h7F);
    @(negedge clk);
    checks++; if (voice_trig !== 8'h01) begin errors++; $display("FAIL rtg2_trig got %h exp 01", voice_trig); end
    checks++; if (voice_gate !== 8'h03) begin errors++; $display("FAIL rtg2_gate got %h exp 03", voice_gate); end
    send(8'hB0); send(8'h07); send(8'h7F);
    @(negedge clk);
    checks++; if (voice_gate !== 8'h03) begin errors++; $display("FAIL cc7_gate got %h exp 03", voice_gate); end
    send(8'h80); send(8'h3E); send(8'h00);
    @(negedge clk);
    checks++; if (voice_gate !== 8'h01) begin errors++; $display("FAIL off_gate got %h exp 01", voice_gate); end
    checks++; if (voice_note[13:7] !== 7'h3E) begin errors++; $display("FAIL off_note_kept got %h exp 3e", voice_note[13:7]); end
    checks++; if (voice_trig !== 8'h00) begin errors++; $display("FAIL off_trig got %h exp 00", voice_trig); end
    send(8'hB0); send(8'h7B); send(8'h00);
    @(negedge clk);
    checks++; if (voice_gate !== 8'h00) begin errors++; $display("FAIL alloff_gate got %h exp 00", voice_gate); end
    @(negedge clk);
    checks++; if (active_count !== 5'd0) begin errors++; $display("FAIL alloff_count got %0d exp 0", active_count); end
  endtask
  task automatic test_reset_mid_message();
    do_reset();
    send(8'h90); send(8'h3C);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send(8'h64);
    checks++; if (bus.midi_ready !== 1'b1) begin errors++; $display("FAIL mid_nostall got %b exp 1", bus.midi_ready); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (voice_gate !== 8'h00) begin errors++; $display("FAIL mid_gate got %h exp 00", voice_gate); end
    checks++; if (voice_note !== 56'h0) begin errors++; $display("FAIL mid_note got %h exp 0", voice_note); end
    checks++; if (voice_vel !== 56'h0) begin errors++; $display("FAIL mid_vel got %h exp 0", voice_vel); end
    checks++; if (active_count !== 5'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", active_count); end
  endtask
  initial begin
    bus.midi_data = 8'h00;
    bus.midi_send = 1'b0;
    @(negedge clk);
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime_filter();
    test_full_pool();
    test_retrigger();
    test_reset_mid_message();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
